// File: rtl/i2c_write_sequencer.sv
// rtl/i2c_write_sequencer.sv - issues a fixed table of register writes through an I2C master
// Each entry is latched into m_addr/m_sub/m_data, started, awaited, then spaced by a gap.
module i2c_write_sequencer #(
  parameter int NUM_ENTRIES    = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      go,
  input  logic                      abort,
  input  logic [NUM_ENTRIES*23-1:0] table_i,
  output logic                      m_start,
  output logic [6:0]                m_addr,
  output logic [7:0]                m_sub,
  output logic [7:0]                m_data,
  input  logic                      m_ready,
  input  logic                      m_done,
  output logic                      busy,
  output logic                      finished,
  output logic                      timeout_err,
  output logic [3:0]                cur_index
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_START, S_WAIT_DONE, S_GAP, S_FINISH, S_ERROR
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [GAP_W-1:0] gap_q;
  logic [TMO_W-1:0] tmo_q;
  logic             m_start_q;
  logic [6:0]       m_addr_q;
  logic [7:0]       m_sub_q;
  logic [7:0]       m_data_q;
  logic             finished_q;
  logic             timeout_err_q;

  // Padded to 16 slots so a 4-bit index always selects a defined entry.
  logic [22:0] entry_arr [16];
  for (genvar k = 0; k < 16; k++) begin : g_entry
    if (k < NUM_ENTRIES) begin : g_used
      assign entry_arr[k] = table_i[23*k +: 23];
    end else begin : g_unused
      assign entry_arr[k] = '0;
    end
  end

  logic [3:0] idx_next;
  logic       in_flight;
  logic       counting;
  logic       take_done;

  assign idx_next  = idx_q + 4'd1;
  assign counting  = (state_q == S_WAIT_READY) || (state_q == S_START) ||
                     (state_q == S_WAIT_DONE);
  assign in_flight = counting || (state_q == S_GAP);
  assign take_done = m_done && ((state_q == S_START) || (state_q == S_WAIT_DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      m_start_q     <= 1'b0;
      m_addr_q      <= '0;
      m_sub_q       <= '0;
      m_data_q      <= '0;
      finished_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      if (counting && tmo_q != TMO_LAST) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if (abort && in_flight) begin
        state_q       <= S_ERROR;
        m_start_q     <= 1'b0;
        timeout_err_q <= 1'b1;
      end else if (counting && tmo_q == TMO_LAST) begin
        state_q       <= S_ERROR;
        m_start_q     <= 1'b0;
        timeout_err_q <= 1'b1;
      end else if (take_done) begin
        // A done seen while still in START counts as accepted and completed.
        m_start_q <= 1'b0;
        if (idx_q == LAST_IDX) begin
          state_q    <= S_FINISH;
          finished_q <= 1'b1;
        end else begin
          idx_q                          <= idx_next;
          {m_addr_q, m_sub_q, m_data_q}  <= entry_arr[idx_next];
          gap_q                          <= '0;
          state_q                        <= S_GAP;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (go) begin
              idx_q                         <= '0;
              timeout_err_q                 <= 1'b0;
              {m_addr_q, m_sub_q, m_data_q} <= entry_arr[4'd0];
              tmo_q                         <= '0;
              state_q                       <= S_WAIT_READY;
            end
          end
          S_WAIT_READY: begin
            if (m_ready) begin
              m_start_q <= 1'b1;
              state_q   <= S_START;
            end
          end
          S_START: begin
            if (!m_ready) begin
              m_start_q <= 1'b0;
              state_q   <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            state_q <= S_WAIT_DONE;
          end
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              tmo_q   <= '0;
              state_q <= S_WAIT_READY;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          S_ERROR: begin
            // Requiring go low as well keeps a held button from re-triggering.
            m_start_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            if (!abort && !go) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign m_start     = m_start_q;
  assign m_addr      = m_addr_q;
  assign m_sub       = m_sub_q;
  assign m_data      = m_data_q;
  assign busy        = in_flight;
  assign finished    = finished_q;
  assign timeout_err = timeout_err_q;
  assign cur_index   = idx_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb/tb_i2c_write_sequencer.sv - directed bench for i2c_write_sequencer with a simple master model
module tb_i2c_write_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [91:0] table_v;
  logic        m_start;
  logic [6:0]  m_addr;
  logic [7:0]  m_sub;
  logic [7:0]  m_data;
  logic        m_ready = 1'b1;
  logic        m_done = 1'b0;
  logic        busy;
  logic        finished;
  logic        timeout_err;
  logic [3:0]  cur_index;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic       mode = 1'b0;
  logic       busy_m = 1'b0;
  logic       start_prev = 1'b0;
  int         cnt = 0;
  int         n_start = 0;
  int         n_done = 0;
  int         n_fin = 0;
  logic [6:0] st_addr [64];
  logic [7:0] st_sub  [64];
  logic [7:0] st_data [64];
  logic [3:0] st_idx  [64];
  int         st_cyc  [64];
  int         done_cyc[64];

  i2c_write_sequencer #(
    .NUM_ENTRIES(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .table_i(table_v),
    .m_start(m_start), .m_addr(m_addr), .m_sub(m_sub), .m_data(m_data),
    .m_ready(m_ready), .m_done(m_done), .busy(busy), .finished(finished),
    .timeout_err(timeout_err), .cur_index(cur_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model: drops ready the cycle after start, pulses done 40 cycles later.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (finished) n_fin++;
    if (m_start && !start_prev) begin
      st_addr[n_start] = m_addr;
      st_sub[n_start]  = m_sub;
      st_data[n_start] = m_data;
      st_idx[n_start]  = cur_index;
      st_cyc[n_start]  = cyc;
      n_start++;
    end
    start_prev = m_start;
    if (mode) begin
      m_ready = 1'b0;
      busy_m  = 1'b0;
    end else if (!busy_m) begin
      m_ready = 1'b1;
      if (m_start) begin
        busy_m  = 1'b1;
        cnt     = 0;
        m_ready = 1'b0;
      end
    end else begin
      cnt++;
      if (cnt == 40) begin
        m_done   = 1'b1;
        busy_m   = 1'b0;
        m_ready  = 1'b1;
        done_cyc[n_done] = cyc;
        n_done++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] exp_addr [4];
  logic [7:0] exp_sub  [4];
  logic [7:0] exp_data [4];

  initial begin
    int base;
    int fbase;
    int g;
    exp_addr = '{7'h68, 7'h68, 7'h1E, 7'h1E};
    exp_sub  = '{8'h20, 8'h23, 8'h00, 8'h01};
    exp_data = '{8'h0F, 8'h80, 8'h55, 8'hAA};
    table_v = {7'h1E, 8'h01, 8'hAA, 7'h1E, 8'h00, 8'h55,
               7'h68, 8'h23, 8'h80, 7'h68, 8'h20, 8'h0F};

    // Reset state
    ticks(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_addr", 32'({m_addr, m_sub, m_data}), 0);
    chk("rst_fin", 32'(finished), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_idx", 32'(cur_index), 0);
    reset_n = 1'b1;
    ticks(2);

    // Normal 4-entry run
    base = n_start;
    go = 1'b1;
    g = cyc;
    tick();
    go = 1'b0;
    for (int i = 0; i < 600 && n_fin == 0; i++) tick();
    chk("run_finished", 32'(n_fin), 1);
    ticks(3);
    chk("run_starts", 32'(n_start - base), 4);
    chk("run_go_lat", 32'(st_cyc[base] - g), 2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("run_addr%0d", k), 32'(st_addr[base+k]), 32'(exp_addr[k]));
      chk($sformatf("run_sub%0d", k), 32'(st_sub[base+k]), 32'(exp_sub[k]));
      chk($sformatf("run_data%0d", k), 32'(st_data[base+k]), 32'(exp_data[k]));
      chk($sformatf("run_idx%0d", k), 32'(st_idx[base+k]), 32'(k));
      if (k > 0) chk($sformatf("run_gap%0d", k), 32'(st_cyc[base+k] - done_cyc[k-1]), 18);
    end
    chk("run_busy_after", 32'(busy), 0);
    chk("run_idx_hold", 32'(cur_index), 3);
    chk("run_fin_once", 32'(n_fin), 1);

    // Timeout with ready stuck low, go held
    mode = 1'b1;
    tick();
    base = n_start;
    go = 1'b1;
    g = cyc;
    while (cyc < g + 64) tick();
    chk("tmo_busy_before", 32'(busy), 1);
    chk("tmo_err_before", 32'(timeout_err), 0);
    tick();
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_no_start", 32'(n_start - base), 0);
    ticks(3);
    chk("tmo_hold_go", 32'(busy), 0);
    go = 1'b0;
    tick();
    chk("tmo_sticky", 32'(timeout_err), 1);
    mode = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("tmo_rego_busy", 32'(busy), 1);
    chk("tmo_rego_clr", 32'(timeout_err), 0);
    fbase = n_fin;
    for (int i = 0; i < 600 && n_fin == fbase; i++) tick();
    chk("tmo_rerun_fin", 32'(n_fin - fbase), 1);
    ticks(3);

    // Abort during WAIT_DONE of entry 2
    base = n_start;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 400 && n_start < base + 3; i++) tick();
    chk("abt_reach2", 32'(n_start - base), 3);
    ticks(5);
    abort = 1'b1;
    tick();
    chk("abt_busy", 32'(busy), 0);
    chk("abt_err", 32'(timeout_err), 1);
    chk("abt_idx", 32'(cur_index), 2);
    go = 1'b1;
    ticks(3);
    abort = 1'b0;
    ticks(3);
    chk("abt_go_held", 32'(busy), 0);
    go = 1'b0;
    ticks(60);
    chk("abt_no_start", 32'(n_start - base), 3);
    chk("abt_idle", 32'(busy), 0);

    // Abort on the same edge as the last m_done
    fbase = n_fin;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 600 && !(m_done === 1'b1 && cur_index == 4'd3); i++) tick();
    chk("sim_last_done", 32'({m_done, cur_index}), 32'h13);
    abort = 1'b1;
    tick();
    chk("sim_busy", 32'(busy), 0);
    chk("sim_err", 32'(timeout_err), 1);
    ticks(2);
    chk("sim_no_fin", 32'(n_fin - fbase), 0);
    abort = 1'b0;
    ticks(3);

    // go held through FINISH
    base = n_start;
    go = 1'b1;
    for (int i = 0; i < 800 && finished !== 1'b1; i++) tick();
    chk("hold_fin_hi", 32'(finished), 1);
    tick();
    chk("hold_fin_width", 32'(finished), 0);
    chk("hold_idle", 32'(busy), 0);
    tick();
    chk("hold_rerun", 32'(busy), 1);
    chk("hold_rerun_idx", 32'(cur_index), 0);
    go = 1'b0;
    for (int i = 0; i < 800 && finished !== 1'b1; i++) tick();
    chk("hold_fin2", 32'(finished), 1);
    ticks(30);
    chk("hold_starts", 32'(n_start - base), 8);
    chk("hold_busy_end", 32'(busy), 0);

    // Reset mid-WAIT_DONE, spurious done afterwards
    base = n_start;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 100 && n_start == base; i++) tick();
    ticks(5);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_start", 32'(m_start), 0);
    chk("mrst_ent", 32'({m_addr, m_sub, m_data}), 0);
    chk("mrst_idx", 32'(cur_index), 0);
    chk("mrst_flags", 32'({finished, timeout_err}), 0);
    tick();
    reset_n = 1'b1;
    ticks(60);
    chk("mrst_ign_busy", 32'(busy), 0);
    chk("mrst_ign_start", 32'(n_start - base), 1);
    chk("mrst_ign_idx", 32'(cur_index), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
